// File: rtl/ixc_assign_arb_pkg.sv
// Shared constants, state type and index-width helper for the assign-channel arbiter.
package ixc_assign_arb_pkg;

   localparam int W_DEFAULT = 73;
   localparam int NREQ_MAX  = 16;

   // Index width for n items, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   typedef enum logic {
      OPEN   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/ixc_rr_pick.sv
// Combinational round-robin picker: first masked request at or after ptr, modulo NREQ.
module ixc_rr_pick
   import ixc_assign_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   input  logic [NREQ-1:0] mask,
   output logic            found,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   index
);

   logic [NREQ-1:0] eligible;
   logic [IW-1:0]   cand;

   assign eligible = req & mask;

   always_comb begin
      found = 1'b0;
      grant = '0;
      index = '0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = IW'((int'(ptr) + k) % NREQ);
         if (!found && eligible[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            index       = cand;
         end
      end
   end

endmodule

// File: rtl/ixc_assign_arb.sv
// Round-robin arbiter sharing one assign channel among NREQ requesters, with burst lock,
// a single-entry output register and a saturating handshake counter.
module ixc_assign_arb
   import ixc_assign_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int W     = W_DEFAULT,
   parameter int CNT_W = 16,
   localparam int IW   = idx_w(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ-1:0]   req_lock,
   input  logic [NREQ*W-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic              out_valid,
   output logic [W-1:0]      out_data,
   output logic [IW-1:0]     out_src,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  xfer_cnt,
   output arb_state_t        dbg_state,
   output logic [IW-1:0]     dbg_owner,
   output logic [IW-1:0]     dbg_ptr
);

   // Handshakes: a requester word transfers when req_valid[i] && req_ready[i];
   // the output word transfers when out_valid && out_ready. out_valid never drops
   // while out_ready is low, and out_data/out_src are stable while held.

   arb_state_t      state;
   logic [IW-1:0]   owner;
   logic [IW-1:0]   ptr;

   logic            can_load;
   logic            accept;
   logic [NREQ-1:0] mask;
   logic            pick_found;
   logic [NREQ-1:0] pick_grant;
   logic [IW-1:0]   pick_idx;
   logic            win_lock;
   logic [W-1:0]    win_data;

   // While locked only the owner is eligible, even if it is idle this cycle.
   always_comb begin
      mask = '1;
      if (state == LOCKED) begin
         mask        = '0;
         mask[owner] = 1'b1;
      end
   end

   ixc_rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .req   (req_valid),
      .ptr   (ptr),
      .mask  (mask),
      .found (pick_found),
      .grant (pick_grant),
      .index (pick_idx)
   );

   // A reset cycle accepts nothing: any word taken now would be discarded.
   assign can_load  = !out_valid || out_ready;
   assign accept    = can_load && pick_found && !rst;
   assign req_ready = accept ? pick_grant : '0;
   assign win_lock  = req_lock[pick_idx];
   assign win_data  = req_data[pick_idx*W +: W];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= OPEN;
         owner     <= '0;
         ptr       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         xfer_cnt  <= '0;
      end else begin
         if (out_valid && out_ready && (xfer_cnt != '1)) begin
            xfer_cnt <= xfer_cnt + 1'b1;
         end
         if (accept) begin
            out_valid <= 1'b1;
            out_data  <= win_data;
            out_src   <= pick_idx;
            if (win_lock) begin
               state <= LOCKED;
               owner <= pick_idx;
            end else begin
               state <= OPEN;
               ptr   <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign dbg_state = state;
   assign dbg_owner = owner;
   assign dbg_ptr   = ptr;

endmodule

// File: tb/tb_ixc_assign_arb.sv
// Bench for ixc_assign_arb: table vectors, directed corner sequences, random traffic
// against a behavioural model, and an expected-word queue for the output stream.
module tb_ixc_assign_arb;
   import ixc_assign_arb_pkg::*;

   localparam int NREQ    = 4;
   localparam int W       = 73;
   localparam int CNT_W   = 16;
   localparam int IW      = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_lock;
   logic [NREQ*W-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic              out_valid;
   logic [W-1:0]      out_data;
   logic [IW-1:0]     out_src;
   logic              out_ready;
   logic [CNT_W-1:0]  xfer_cnt;
   arb_state_t        dbg_state;
   logic [IW-1:0]     dbg_owner;
   logic [IW-1:0]     dbg_ptr;

   // clock / reset
   always #5 clk = ~clk;

   ixc_assign_arb #(
      .NREQ  (NREQ),
      .W     (W),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_lock  (req_lock),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready),
      .xfer_cnt  (xfer_cnt),
      .dbg_state (dbg_state),
      .dbg_owner (dbg_owner),
      .dbg_ptr   (dbg_ptr)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // behavioural model state
   logic         m_valid;
   logic [W-1:0] m_data;
   int           m_src;
   int           m_ptr;
   logic         m_locked;
   int           m_owner;
   int           m_cnt;
   int           m_win;

   logic [W-1:0] exp_q[$];

   typedef struct {
      logic [NREQ-1:0] v;
      logic [NREQ-1:0] l;
      logic            r;
      logic [NREQ-1:0] er;
      logic            eov;
      logic [IW-1:0]   esrc;
      int              ecnt;
   } vec_t;

   localparam int NTBL = 23;
   vec_t tbl[NTBL];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [W-1:0] rand_word();
      logic [95:0] t;
      t = {$urandom, $urandom, $urandom};
      return t[W-1:0];
   endfunction

   task automatic model_reset();
      m_valid  = 1'b0;
      m_data   = '0;
      m_src    = 0;
      m_ptr    = 0;
      m_locked = 1'b0;
      m_owner  = 0;
      m_cnt    = 0;
      exp_q.delete();
   endtask

   // Which requester the rules say wins this cycle (-1 for none).
   task automatic model_comb();
      m_win = -1;
      if (!rst && (!m_valid || out_ready)) begin
         if (m_locked) begin
            if (req_valid[m_owner]) m_win = m_owner;
         end else begin
            for (int k = 0; k < NREQ; k++) begin
               int i;
               i = (m_ptr + k) % NREQ;
               if (m_win < 0 && req_valid[i]) m_win = i;
            end
         end
      end
   endtask

   // driver tasks
   task automatic drive(input logic [NREQ-1:0] v, input logic [NREQ-1:0] l, input logic r);
      req_valid = v;
      req_lock  = l;
      out_ready = r;
      for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = rand_word();
   endtask

   // Compare at the falling edge, when inputs and registered outputs are settled.
   task automatic sample_check(input bit cmp);
      logic [NREQ-1:0] e_ready;
      logic [W-1:0]    e_word;
      @(negedge clk);
      model_comb();
      e_ready = '0;
      if (m_win >= 0) e_ready[m_win] = 1'b1;
      if (cmp) begin
         chk("req_ready", req_ready, e_ready);
         chk("out_valid", out_valid, m_valid);
         chk("out_data",  out_data,  m_data);
         chk("out_src",   out_src,   m_src);
         chk("xfer_cnt",  xfer_cnt,  m_cnt);
         chk("state",     dbg_state, m_locked);
         chk("ptr",       dbg_ptr,   m_ptr);
         if (m_locked) chk("owner", dbg_owner, m_owner);
      end
      // scoreboard: every output handshake must carry the oldest accepted word
      if (!rst && m_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            if (cmp) chk("sb_empty", 1, 0);
         end else begin
            e_word = exp_q.pop_front();
            if (cmp) chk("sb_word", out_data, e_word);
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (m_valid && out_ready && m_cnt < CNT_MAX) m_cnt++;
         if (m_win >= 0) begin
            m_valid = 1'b1;
            m_data  = req_data[m_win*W +: W];
            m_src   = m_win;
            exp_q.push_back(m_data);
            if (req_lock[m_win]) begin
               m_locked = 1'b1;
               m_owner  = m_win;
            end else begin
               m_locked = 1'b0;
               m_ptr    = (m_win + 1) % NREQ;
            end
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
         end
      end
      #1;
   endtask

   initial begin
      logic [W-1:0] hold_word;
      hold_word = 73'h1_FFFF_FFFF_FFFF_FFFF;

      tbl[0]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0, 0};
      tbl[1]  = '{4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd0, 0};
      tbl[2]  = '{4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd1, 1};
      tbl[3]  = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd2, 2};
      tbl[4]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd3, 3};
      tbl[5]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 4};
      tbl[6]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 5};
      tbl[7]  = '{4'b1010, 4'b0010, 1'b1, 4'b0010, 1'b0, 2'd0, 5};
      tbl[8]  = '{4'b1010, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 5};
      tbl[9]  = '{4'b1010, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 6};
      tbl[10] = '{4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd1, 7};
      tbl[11] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 8};
      tbl[12] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 9};
      tbl[13] = '{4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b0, 2'd3, 9};
      tbl[14] = '{4'b1001, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 9};
      tbl[15] = '{4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b0, 2'd1, 10};
      tbl[16] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 10};
      tbl[17] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 11};
      tbl[18] = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b0, 2'd1, 11};
      tbl[19] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd2, 11};
      tbl[20] = '{4'b0011, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd0, 12};
      tbl[21] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 13};
      tbl[22] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 14};

      rst = 1'b1;
      drive('0, '0, 1'b0);
      model_reset();
      advance();
      advance();
      rst = 1'b0;

      // reset state
      sample_check(1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data",  out_data,  0);
      chk("rst_out_src",   out_src,   0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_xfer_cnt",  xfer_cnt,  0);
      chk("rst_state",     dbg_state, OPEN);
      chk("rst_ptr",       dbg_ptr,   0);
      advance();

      // rotation, lock bursts, idle owner, wrap-around, back-to-back refill
      for (int c = 0; c < NTBL; c++) begin
         drive(tbl[c].v, tbl[c].l, tbl[c].r);
         sample_check(1);
         chk($sformatf("tbl%0d_ready", c),     req_ready, tbl[c].er);
         chk($sformatf("tbl%0d_out_valid", c), out_valid, tbl[c].eov);
         chk($sformatf("tbl%0d_out_src", c),   out_src,   tbl[c].esrc);
         chk($sformatf("tbl%0d_xfer_cnt", c),  xfer_cnt,  tbl[c].ecnt);
         advance();
      end

      // reset while holding a word in LOCKED(2)
      drive(4'b0100, 4'b0100, 1'b0);
      sample_check(1);
      advance();
      drive(4'b0100, 4'b0000, 1'b1);
      rst = 1'b1;
      sample_check(1);
      chk("prerst_state", dbg_state, LOCKED);
      chk("prerst_owner", dbg_owner, 2);
      chk("prerst_valid", out_valid, 1);
      chk("prerst_ready", req_ready, 0);
      advance();
      rst = 1'b0;
      drive('0, '0, 1'b0);
      sample_check(1);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_state",     dbg_state, OPEN);
      chk("midrst_ptr",       dbg_ptr,   0);
      chk("midrst_xfer_cnt",  xfer_cnt,  0);
      advance();

      // output hold under backpressure
      drive(4'b0100, 4'b0000, 1'b0);
      req_data[2*W +: W] = hold_word;
      sample_check(1);
      chk("hold_accept", req_ready, 4'b0100);
      advance();
      for (int c = 0; c < 3; c++) begin
         drive(4'b0100, 4'b0000, 1'b0);
         sample_check(1);
         chk($sformatf("hold%0d_valid", c), out_valid, 1);
         chk($sformatf("hold%0d_data", c),  out_data,  hold_word);
         chk($sformatf("hold%0d_ready", c), req_ready, 0);
         advance();
      end
      drive(4'b0000, 4'b0000, 1'b1);
      sample_check(1);
      advance();
      drive(4'b0000, 4'b0000, 1'b0);
      sample_check(1);
      chk("hold_drained", out_valid, 0);
      chk("hold_cnt",     xfer_cnt,  1);
      advance();

      // random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         logic [NREQ-1:0] v;
         logic [NREQ-1:0] l;
         for (int i = 0; i < NREQ; i++) begin
            v[i] = ($urandom_range(0, 1) == 1);
            l[i] = ($urandom_range(0, 3) == 0);
         end
         drive(v, l, ($urandom_range(0, 3) != 0));
         rst = ($urandom_range(0, 255) == 0);
         sample_check(1);
         advance();
      end
      rst = 1'b1;
      drive('0, '0, 1'b0);
      sample_check(0);
      advance();
      rst = 1'b0;

      // counter saturation under continuous full-rate traffic
      for (int c = 0; c < CNT_MAX + 4; c++) begin
         drive('1, '0, 1'b1);
         sample_check(0);
         advance();
      end
      sample_check(1);
      chk("sat_cnt", xfer_cnt, 16'hFFFF);
      advance();
      for (int c = 0; c < 4; c++) begin
         drive('1, '0, 1'b1);
         sample_check(1);
         advance();
      end
      sample_check(1);
      chk("sat_hold", xfer_cnt, 16'hFFFF);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ixc_assign_arb.md
Name: ixc_assign_arb

Overview:
- Round-robin arbiter and sequencer that shares one 73-bit assign channel between NREQ requesters.
- Selects one requester per cycle, captures its word into a single-entry output register, and presents it downstream with a valid/ready handshake.
- Supports per-requester lock for back-to-back bursts.
- Keeps a saturating transfer counter for emulation debug visibility.

Parameters:
- NREQ, 4, number of requesters (2..16)
- W, 73, channel data width in bits
- CNT_W, 16, width of the transfer counter

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NREQ  per-requester word valid
- req_lock  input  NREQ  requester keeps the grant after this word (burst)
- req_data  input  NREQ*W  requester i data at bits [i*W +: W]
- req_ready  output  NREQ  one-hot (or zero) accept strobe, combinational
- out_valid  output  1  output register holds a word
- out_data  output  W  captured word
- out_src  output  $clog2(NREQ)  index of the requester that supplied out_data
- out_ready  input  1  downstream accepts out_data this cycle
- xfer_cnt  output  CNT_W  count of completed output handshakes, saturating

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_src=0, req_ready=0, xfer_cnt=0, rr pointer ptr=0, lock cleared (state OPEN).
- Reset has priority over all other events. A word held in the output register is dropped without handshake, and xfer_cnt is not incremented.
- can_load = !out_valid || out_ready.
  - The register is refilled in the same cycle it drains, giving 1 word/cycle throughput.
- Arbitration in state OPEN:
  - winner = first i with req_valid[i], scanning ptr, ptr+1, ... modulo NREQ.
- Arbitration in state LOCKED(owner):
  - Only owner is eligible. Other requests are ignored even if owner is idle.
- Accept cycle (can_load and an eligible request exists):
  - req_ready[winner]=1; all other req_ready bits are 0.
  - Next edge: out_data <= req_data[winner], out_src <= winner, out_valid <= 1.
- req_ready is 0 for all requesters when can_load=0 or no request is eligible.
- Pointer update on accept:
  - req_lock[winner]=1: state -> LOCKED(winner); ptr unchanged.
  - req_lock[winner]=0: state -> OPEN; ptr <= (winner+1) mod NREQ, wrapping at NREQ-1 -> 0.
- LOCKED exits only through an accepted word with req_lock=0, or through reset.
- Drain with no new accept (out_valid && out_ready, no eligible request): out_valid <= 0. out_data and out_src hold their last value.
- Hold (out_valid && !out_ready): out_data and out_src are stable, and req_ready is all zero.
- xfer_cnt increments on each out_valid && out_ready edge and saturates at 2^CNT_W-1, with no wrap.
- Latency: request accepted in cycle N appears with out_valid=1 in cycle N+1.
- Requesters may drop req_valid without being granted; no request is remembered across cycles.
- State register: 2-state enum OPEN/LOCKED plus a registered owner index. Output register state is tracked by out_valid alone.

Decomposition:
- Package ixc_assign_arb_pkg:
  - W default constant (73).
  - NREQ_MAX (16).
  - Function idx_w(n) returning $clog2 with a minimum of 1.
  - Enum arb_state_t {OPEN, LOCKED}.
- Sub-module ixc_rr_pick: combinational round-robin picker.
  - Inputs: req vector, ptr, mask.
  - Outputs: found, one-hot grant, binary index.
  - Instantiated once; LOCKED mode passes a one-hot mask of owner.

Test Plan:
- Reset then all four req_valid=1, lock=0, out_ready=1: grants 0,1,2,3,0 on consecutive cycles; out_src follows 0,1,2,3,0 one cycle later; xfer_cnt=5 after 5 handshakes.
- req_valid[2]=1 with req_data[2]=73'h1_FFFF_FFFF_FFFF_FFFF, out_ready=0 for 3 cycles: out_valid=1 and out_data stable for all 3 cycles, req_ready all 0; out_ready=1 then drains, xfer_cnt=1.
- Requester 1 sends 3 words with lock=1,1,0 while requester 3 is also valid: out_src=1,1,1 then 3; ptr=2 after the unlock.
- ptr=3 with only req_valid[0] set: wrap-around grants 0; ptr becomes 1.
- Simultaneous drain and refill (out_valid=1, out_ready=1, req_valid[1]=1): out_valid stays 1 with no bubble, out_data updates; out_valid=0 follows only when no request remains.
- rst asserted while out_valid=1 and LOCKED(2): next cycle out_valid=0, state OPEN, ptr=0, xfer_cnt=0. Preset xfer_cnt near 16'hFFFF: saturates at 16'hFFFF.
